// File: rtl/fetch_unit_if.sv
// Fetch-side buses: shared memory read port and the
// valid/ready instruction handshake toward decode.
interface fetch_unit_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] instr_opcode;
  logic [DATA_WIDTH-1:0] instr_operand;
  logic [ADDR_WIDTH-1:0] instr_pc;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata,
    output instr_valid,
    input  instr_ready,
    output instr_opcode,
    output instr_operand,
    output instr_pc
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata,
    input  instr_valid,
    output instr_ready,
    input  instr_opcode,
    input  instr_operand,
    input  instr_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequences the PC, fetches
// 1/2-byte instructions and hands them to decode.
module fetch_unit #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] current_address,
  output logic [ADDR_WIDTH-1:0] next_address,
  input  logic                  bus_hold,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  fetch_unit_if.master          bus
);

  typedef enum logic [1:0] {
    FETCH_OP,
    FETCH_ARG,
    ISSUE
  } state_t;

  state_t                state;
  logic                  fetching;
  logic                  req;
  logic                  xfer;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] opcode_q;
  logic [DATA_WIDTH-1:0] operand_q;
  logic [ADDR_WIDTH-1:0] pc_q;

  assign fetching = (state != ISSUE);
  assign req      = !reset && fetching
                  && !bus_hold && !redirect_valid;
  assign xfer     = req && bus.mem_ack;

  assign bus.mem_req       = req;
  assign bus.mem_addr      = current_address;
  assign bus.instr_valid   = valid_q;
  assign bus.instr_opcode  = opcode_q;
  assign bus.instr_operand = operand_q;
  assign bus.instr_pc      = pc_q;

  always_comb begin
    next_address = current_address;
    if (reset)
      next_address = '0;
    else if (redirect_valid)
      next_address = redirect_addr;
    else if (xfer)
      next_address = current_address + 1'b1;
  end

  // Redirect outranks every FSM action, including a
  // same-cycle ack or decode handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= FETCH_OP;
      valid_q   <= 1'b0;
      opcode_q  <= '0;
      operand_q <= '0;
      pc_q      <= '0;
    end else if (redirect_valid) begin
      state   <= FETCH_OP;
      valid_q <= 1'b0;
    end else begin
      unique case (state)
        FETCH_OP: begin
          if (xfer) begin
            opcode_q  <= bus.mem_rdata;
            operand_q <= '0;
            pc_q      <= current_address;
            if (bus.mem_rdata[7]) begin
              state <= FETCH_ARG;
            end else begin
              state   <= ISSUE;
              valid_q <= 1'b1;
            end
          end
        end
        FETCH_ARG: begin
          if (xfer) begin
            operand_q <= bus.mem_rdata;
            state     <= ISSUE;
            valid_q   <= 1'b1;
          end
        end
        ISSUE: begin
          if (bus.instr_ready) begin
            state   <= FETCH_OP;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state   <= FETCH_OP;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
